// File: rtl/ram_arbiter.sv
// Arbitrates the data RAM between the CPU datapath and a host/loader port.
// The CPU owns the RAM by default; a pending host request is granted at most HOST_WAIT_MAX blocked cycles later.
module ram_arbiter #(
  parameter int unsigned ADDR_W             = 12,
  parameter int unsigned DATA_W             = 4,
  parameter int unsigned HOST_WAIT_MAX      = 8,
  parameter int unsigned HOST_ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_done,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wdata_oe,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  localparam logic [7:0] WAIT_MAX = 8'(HOST_WAIT_MAX);
  localparam logic [3:0] ACC_LAST = 4'(HOST_ACCESS_CYCLES - 1);

  state_t              state_q, state_d;
  logic [7:0]          wait_q, wait_d;
  logic [3:0]          acc_q, acc_d;
  logic                hwe_q, hwe_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      acc_q    <= '0;
      hwe_q    <= 1'b0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      acc_q    <= acc_d;
      hwe_q    <= hwe_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    acc_d    = acc_q;
    hwe_d    = hwe_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (host_req && (!cpu_cs || wait_q == WAIT_MAX)) begin
          state_d  = GRANT;
          hwe_d    = host_we;
          haddr_d  = host_addr;
          hwdata_d = host_wdata;
          acc_d    = '0;
          wait_d   = '0;
        end else if (host_req) begin
          // Only reached with cpu_cs high and wait_q below the limit.
          wait_d = wait_q + 8'd1;
        end else begin
          wait_d = '0;
        end
      end
      GRANT: begin
        acc_d = acc_q + 4'd1;
        if (acc_q == ACC_LAST) begin
          if (!hwe_q) rdata_d = ram_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_cs       = cpu_cs;
    ram_we       = cpu_we;
    ram_addr     = cpu_addr;
    ram_wdata    = '0;
    ram_wdata_oe = 1'b0;
    cpu_stall    = 1'b0;
    host_gnt     = 1'b0;
    host_done    = 1'b0;
    unique case (state_q)
      GRANT: begin
        ram_cs       = 1'b1;
        ram_we       = hwe_q;
        ram_addr     = haddr_q;
        ram_wdata    = hwdata_q;
        ram_wdata_oe = hwe_q;
        cpu_stall    = cpu_cs;
        host_gnt     = 1'b1;
      end
      DONE:    host_done = 1'b1;
      default: ;
    endcase
  end

  assign host_rdata = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, host read-data scoreboard, timing checks.
module tb_ram_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 4;
  localparam int WMX = 8;
  localparam int HAC = 2;
  localparam int PERIOD = WMX + 1 + HAC + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_cs = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic cpu_stall;
  logic host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic host_gnt, host_done;
  logic [DW-1:0] host_rdata;
  logic ram_cs, ram_we, ram_wdata_oe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_WAIT_MAX(WMX), .HOST_ACCESS_CYCLES(HAC)) dut (
    .clk(clk), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_done(host_done), .host_rdata(host_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wdata_oe(ram_wdata_oe), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata_oe ? ram_wdata : cpu_wdata;
  assign ram_rdata = mem[ram_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one host access starting at cycle 0 and measures what the DUT does; no checking here.
  task automatic run_host(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input bit pulse, input int budget,
                          output int g_start, output int g_len, output int d_at, output int d_cnt,
                          output int stall_out, output int stall_in, output int bad_ram,
                          output logic [DW-1:0] rd);
    g_start = -1; g_len = 0; d_at = -1; d_cnt = 0;
    stall_out = 0; stall_in = 0; bad_ram = 0; rd = 'x;
    host_we = we; host_addr = addr; host_wdata = wd; host_req = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (host_gnt) begin
        if (g_start < 0) g_start = c;
        g_len++;
        if (cpu_stall) stall_in++;
        if (ram_cs !== 1'b1 || ram_we !== we || ram_addr !== addr || ram_wdata_oe !== we ||
            (we && ram_wdata !== wd)) bad_ram++;
      end else begin
        if (cpu_stall) stall_out++;
        if (ram_cs !== cpu_cs || ram_we !== cpu_we || ram_addr !== cpu_addr || ram_wdata_oe !== 1'b0)
          bad_ram++;
      end
      if (host_done) begin
        d_cnt++;
        if (d_at < 0) begin d_at = c; rd = host_rdata; end
      end
      @(posedge clk); #1;
      if (pulse || g_start >= 0) host_req = 1'b0;
      if (d_at >= 0 && c >= d_at + 3) break;
    end
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_assert++; if (host_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b exp 0", host_gnt); end
    n_assert++; if (host_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b exp 0", host_done); end
    n_assert++; if (host_rdata !== 4'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", host_rdata); end
    n_assert++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b exp 0", cpu_stall); end
    n_assert++; if (ram_wdata_oe !== 1'b0 || ram_cs !== 1'b0) begin n_fail++; $display("FAIL rst_ram: got cs=%b oe=%b exp 0 0", ram_cs, ram_wdata_oe); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int gs, gl, da, dc, so, si, br;
    logic [DW-1:0] rd, exp;
    cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000;
    sb.push_back(4'h0);
    run_host(1'b1, 12'h123, 4'hA, 1'b0, 40, gs, gl, da, dc, so, si, br, rd);
    n_assert++; if (gs !== 1) begin n_fail++; $display("FAIL wr_gnt_start: got %0d exp 1", gs); end
    n_assert++; if (gl !== HAC) begin n_fail++; $display("FAIL wr_gnt_len: got %0d exp %0d", gl, HAC); end
    n_assert++; if (da !== HAC + 1) begin n_fail++; $display("FAIL wr_done_at: got %0d exp %0d", da, HAC + 1); end
    n_assert++; if (br !== 0) begin n_fail++; $display("FAIL wr_ram_bus: got %0d bad cycles exp 0", br); end
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    n_assert++; if (rd !== exp) begin n_fail++; $display("FAIL wr_rdata_hold: got %h exp %h", rd, exp); end
    sb.push_back(4'hA);
    run_host(1'b0, 12'h123, 4'h0, 1'b0, 40, gs, gl, da, dc, so, si, br, rd);
    n_assert++; if (da !== HAC + 1) begin n_fail++; $display("FAIL rd_done_at: got %0d exp %0d", da, HAC + 1); end
    n_assert++; if (br !== 0) begin n_fail++; $display("FAIL rd_ram_bus: got %0d bad cycles exp 0", br); end
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    n_assert++; if (rd !== exp) begin n_fail++; $display("FAIL rd_rdata: got %h exp %h", rd, exp); end
  endtask

  task automatic test_cpu_busy();
    int gs, gl, da, dc, so, si, br;
    logic [DW-1:0] rd, exp;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h5A5;
    sb.push_back(4'hA);
    run_host(1'b1, 12'h456, 4'h3, 1'b0, 40, gs, gl, da, dc, so, si, br, rd);
    n_assert++; if (gs !== WMX + 1) begin n_fail++; $display("FAIL busy_gnt_start: got %0d exp %0d", gs, WMX + 1); end
    n_assert++; if (si !== HAC) begin n_fail++; $display("FAIL busy_stall_in_gnt: got %0d exp %0d", si, HAC); end
    n_assert++; if (so !== 0) begin n_fail++; $display("FAIL busy_stall_outside: got %0d exp 0", so); end
    n_assert++; if (da !== WMX + 1 + HAC) begin n_fail++; $display("FAIL busy_done_at: got %0d exp %0d", da, WMX + 1 + HAC); end
    n_assert++; if (br !== 0) begin n_fail++; $display("FAIL busy_ram_bus: got %0d bad cycles exp 0", br); end
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    n_assert++; if (rd !== exp) begin n_fail++; $display("FAIL busy_rdata_hold: got %h exp %h", rd, exp); end
    cpu_cs = 1'b0;
  endtask

  task automatic test_pulse();
    int gs, gl, da, dc, so, si, br;
    logic [DW-1:0] rd, exp;
    cpu_cs = 1'b0; cpu_addr = 12'h000;
    sb.push_back(4'hA);
    run_host(1'b1, 12'h3C7, 4'h5, 1'b1, 40, gs, gl, da, dc, so, si, br, rd);
    n_assert++; if (dc !== 1) begin n_fail++; $display("FAIL pulse_done_count: got %0d exp 1", dc); end
    n_assert++; if (gl !== HAC) begin n_fail++; $display("FAIL pulse_gnt_len: got %0d exp %0d", gl, HAC); end
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    n_assert++; if (rd !== exp) begin n_fail++; $display("FAIL pulse_rdata_hold: got %h exp %h", rd, exp); end
    sb.push_back(4'h5);
    run_host(1'b0, 12'h3C7, 4'h0, 1'b1, 40, gs, gl, da, dc, so, si, br, rd);
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    n_assert++; if (rd !== exp) begin n_fail++; $display("FAIL pulse_readback: got %h exp %h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    int starts[3], dones[3];
    int ns = 0, nd = 0, so = 0;
    logic prev_gnt = 1'b0;
    logic [DW-1:0] exp;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h777;
    for (int k = 0; k < 3; k++) sb.push_back(4'h3);
    host_we = 1'b0; host_addr = 12'h456; host_wdata = 4'h0; host_req = 1'b1;
    for (int c = 0; c < 3 * PERIOD + 10; c++) begin
      @(negedge clk);
      if (host_gnt && !prev_gnt && ns < 3) begin starts[ns] = c; ns++; end
      if (!host_gnt && cpu_stall) so++;
      if (host_done && nd < 3) begin
        dones[nd] = c; nd++;
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_assert++; if (host_rdata !== exp) begin n_fail++; $display("FAIL b2b_rdata%0d: got %h exp %h", nd, host_rdata, exp); end
      end
      prev_gnt = host_gnt;
      @(posedge clk); #1;
      if (nd == 3) break;
    end
    host_req = 1'b0;
    n_assert++; if (nd !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d exp 3", nd); end
    for (int k = 0; k < 3; k++) begin
      if (k < ns) begin
        n_assert++;
        if (starts[k] !== WMX + 1 + k * PERIOD) begin n_fail++; $display("FAIL b2b_gnt_start%0d: got %0d exp %0d", k, starts[k], WMX + 1 + k * PERIOD); end
      end
      if (k < nd) begin
        n_assert++;
        if (dones[k] !== WMX + 1 + HAC + k * PERIOD) begin n_fail++; $display("FAIL b2b_done_at%0d: got %0d exp %0d", k, dones[k], WMX + 1 + HAC + k * PERIOD); end
      end
    end
    n_assert++; if (so !== 0) begin n_fail++; $display("FAIL b2b_stall_outside: got %0d exp 0", so); end
    cpu_cs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_grant();
    cpu_cs = 1'b0; cpu_addr = 12'h000;
    host_we = 1'b0; host_addr = 12'h123; host_req = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    host_req = 1'b0;
    @(negedge clk);
    n_assert++; if (host_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt1: got %b exp 1", host_gnt); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_assert++; if (host_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt2: got %b exp 1", host_gnt); end
    @(negedge clk);
    n_assert++; if (host_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_rst_gnt: got %b exp 0", host_gnt); end
    n_assert++; if (host_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b exp 0", host_done); end
    n_assert++; if (host_rdata !== 4'h0) begin n_fail++; $display("FAIL mid_rst_rdata: got %h exp 0", host_rdata); end
    n_assert++; if (ram_cs !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ram_cs: got %b exp 0", ram_cs); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_assert++; if (host_done !== 1'b0 || host_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_after: got done=%b gnt=%b exp 0 0", host_done, host_gnt); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_cpu_busy();
    test_pulse();
    test_back_to_back();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
